// File: rtl/layer_serializer.sv
// Collects the parallel outputs of one neuron layer into a holding buffer, then
// replays them as a gap-free serial word stream starting at neuron 0.
module layer_serializer #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NN-1:0]             i_valid,
    input  logic [NN*dataWidth-1:0]   x_in,
    output logic                      o_valid,
    output logic [dataWidth-1:0]      x_out,
    output logic                      o_last,
    output logic [$clog2(NN)-1:0]     o_idx,
    output logic                      busy,
    output logic                      overflow
);

    localparam int IW = $clog2(NN);
    localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] SHIFT   = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [NN-1:0]        mask_q, mask_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 ovf_q, ovf_d;
    logic [dataWidth-1:0] buf_q [NN];
    logic [NN-1:0]        buf_we;
    logic [NN-1:0]        mask_new;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q;
        buf_we   = '0;
        mask_new = mask_q | i_valid;
        case (state_q)
            COLLECT: begin
                // Only first arrivals are captured; a repeat for a neuron already held is an error.
                buf_we = i_valid & ~mask_q;
                if (|(i_valid & mask_q)) ovf_d = 1'b1;
                if (&mask_new) begin
                    state_d = SHIFT;
                    idx_d   = '0;
                    mask_d  = '0;
                end else begin
                    mask_d = mask_new;
                end
            end
            SHIFT: begin
                if (|i_valid) ovf_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = COLLECT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = COLLECT;
                idx_d   = '0;
                mask_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            mask_q  <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset term is needed here.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NN; i++) begin
            if (buf_we[i]) buf_q[i] <= x_in[i*dataWidth +: dataWidth];
        end
    end

    always_comb begin
        busy     = (state_q == SHIFT);
        o_valid  = busy;
        o_last   = busy && (idx_q == LAST_IDX);
        o_idx    = busy ? idx_q : '0;
        x_out    = busy ? buf_q[idx_q] : '0;
        overflow = ovf_q;
    end

endmodule

// File: tb/tb_layer_serializer.sv
// Bench for layer_serializer: directed scenarios plus random valid patterns,
// compared each cycle against a queue-based model of the emitted word stream.
module tb_layer_serializer;

    localparam int NN = 4;
    localparam int DW = 16;
    localparam int IW = 2;
    localparam int EW = IW + DW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NN-1:0]        i_valid = '0;
    logic [NN*DW-1:0]     x_in = '0;
    logic                 o_valid;
    logic [DW-1:0]        x_out;
    logic                 o_last;
    logic [IW-1:0]        o_idx;
    logic                 busy;
    logic                 overflow;

    layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .x_in(x_in),
        .o_valid(o_valid), .x_out(x_out), .o_last(o_last), .o_idx(o_idx),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid_seen = 0;

    // Model: words still to be emitted, each {neuron index, data}.
    logic [EW-1:0]  exp_q[$];
    logic [DW-1:0]  m_word [NN];
    logic [NN-1:0]  m_have;
    logic           m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_have = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic compare_outputs();
        logic [EW-1:0] f;
        if (o_valid === 1'b1) n_valid_seen++;
        if (exp_q.size() > 0) begin
            f = exp_q[0];
            check("o_valid", 32'(o_valid), 32'd1);
            check("busy",    32'(busy),    32'd1);
            check("x_out",   32'(x_out),   32'(f[DW-1:0]));
            check("o_idx",   32'(o_idx),   32'(f[EW-1:DW]));
            check("o_last",  32'(o_last),  32'(f[EW-1:DW] == IW'(NN-1)));
        end else begin
            check("o_valid_idle", 32'(o_valid), 32'd0);
            check("busy_idle",    32'(busy),    32'd0);
            check("x_out_idle",   32'(x_out),   32'd0);
            check("o_idx_idle",   32'(o_idx),   32'd0);
            check("o_last_idle",  32'(o_last),  32'd0);
        end
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Effect of one clock edge on the model, given the inputs held during that cycle.
    task automatic model_edge(input logic [NN-1:0] v, input logic [NN*DW-1:0] x);
        if (exp_q.size() > 0) begin
            if (v != 0) m_ovf = 1'b1;
            void'(exp_q.pop_front());
        end else begin
            for (int i = 0; i < NN; i++) begin
                if (v[i]) begin
                    if (m_have[i]) m_ovf = 1'b1;
                    else begin
                        m_have[i] = 1'b1;
                        m_word[i] = x[i*DW +: DW];
                    end
                end
            end
            if (m_have == {NN{1'b1}}) begin
                for (int i = 0; i < NN; i++) exp_q.push_back({IW'(i), m_word[i]});
                m_have = '0;
            end
        end
    endtask

    task automatic step(input logic [NN-1:0] v, input logic [NN*DW-1:0] x);
        i_valid = v;
        x_in    = x;
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_edge(v, x);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_valid = '0;
        x_in = '0;
        model_clear();
        @(negedge clk);
        compare_outputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NN*DW-1:0] pack4(input logic [DW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    int start_cnt;

    initial begin
        model_clear();
        do_reset();

        // Aligned frame
        step(4'b1111, pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004));
        idle(6);

        // Skewed arrival
        do_reset();
        step(4'b0101, pack4(16'h000A, 16'h0000, 16'h000C, 16'h0000));
        idle(1);
        step(4'b0010, pack4(16'h0000, 16'h000B, 16'h0000, 16'h0000));
        idle(2);
        step(4'b1000, pack4(16'h0000, 16'h0000, 16'h0000, 16'h000D));
        idle(5);
        check("skew_no_overflow", 32'(overflow), 32'd0);

        // Duplicate in COLLECT
        do_reset();
        step(4'b0001, pack4(16'h1111, 16'h0, 16'h0, 16'h0));
        step(4'b0001, pack4(16'h2222, 16'h0, 16'h0, 16'h0));
        step(4'b1110, pack4(16'h0, 16'h1112, 16'h1113, 16'h1114));
        idle(6);
        check("dup_overflow_sticky", 32'(overflow), 32'd1);

        // Valid during SHIFT, then a normal frame
        do_reset();
        step(4'b1111, pack4(16'h0021, 16'h0022, 16'h0023, 16'h0024));
        idle(1);
        step(4'b1111, pack4(16'h0F01, 16'h0F02, 16'h0F03, 16'h0F04));
        idle(7);
        step(4'b1111, pack4(16'h0031, 16'h0032, 16'h0033, 16'h0034));
        idle(5);

        // Back-to-back frames
        do_reset();
        start_cnt = n_valid_seen;
        step(4'b1111, pack4(16'h0041, 16'h0042, 16'h0043, 16'h0044));
        idle(4);
        step(4'b1111, pack4(16'h0051, 16'h0052, 16'h0053, 16'h0054));
        idle(5);
        check("b2b_valid_cycles", 32'(n_valid_seen - start_cnt), 32'd8);
        check("b2b_no_overflow", 32'(overflow), 32'd0);

        // Reset mid-SHIFT at idx=2
        do_reset();
        step(4'b1111, pack4(16'h0061, 16'h0062, 16'h0063, 16'h0064));
        idle(2);
        i_valid = '0;
        x_in = '0;
        @(negedge clk);
        compare_outputs();
        #1 rst = 1'b1;
        #1;
        check("rst_async_o_valid", 32'(o_valid), 32'd0);
        check("rst_async_x_out",   32'(x_out),   32'd0);
        check("rst_async_busy",    32'(busy),    32'd0);
        model_clear();
        @(posedge clk);
        #1;
        do_reset();
        idle(2);
        step(4'b1111, pack4(16'h0005, 16'h0006, 16'h0007, 16'h0008));
        idle(5);

        // Random valid patterns with random data
        do_reset();
        for (int k = 0; k < 400; k++) begin
            logic [NN-1:0]    v;
            logic [NN*DW-1:0] x;
            for (int i = 0; i < NN; i++) begin
                v[i] = ($urandom_range(0, 2) == 0);
                x[i*DW +: DW] = DW'($urandom);
            end
            if ($urandom_range(0, 3) == 0) v = '0;
            step(v, x);
            if (k == 200) do_reset();
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
